// File: rtl/vga_pkg.sv
// Shared VGA constants: visible area, RGB 3:3:2 colour type, colour
// constants and the bit positions of each channel in a packed colour.
package vga_pkg;

   localparam int unsigned PIX_W    = 10;
   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned V_ACTIVE = 480;

   typedef logic [7:0] rgb332_t;

   localparam rgb332_t C_BLANK  = 8'h00;
   localparam rgb332_t C_BG     = 8'h03;
   localparam rgb332_t C_FILL   = 8'hE0;
   localparam rgb332_t C_BORDER = 8'hFF;

   localparam int unsigned R_HI = 7;
   localparam int unsigned R_LO = 5;
   localparam int unsigned G_HI = 4;
   localparam int unsigned G_LO = 2;
   localparam int unsigned B_HI = 1;
   localparam int unsigned B_LO = 0;

endpackage

// File: rtl/vga_control_module_if.sv
// Pixel coordinate/active-video inputs and RGB 3:3:2 DAC outputs of the
// colour generator, grouped so the sync block and DAC side connect as one.
interface vga_control_module_if;
   import vga_pkg::*;

   logic [PIX_W-1:0] X;
   logic [PIX_W-1:0] Y;
   logic             valid;
   logic [2:0]       VGA_R;
   logic [2:0]       VGA_G;
   logic [1:0]       VGA_B;

   modport master (output X, output Y, output valid,
                   input VGA_R, input VGA_G, input VGA_B);
   modport slave  (input X, input Y, input valid,
                   output VGA_R, output VGA_G, output VGA_B);

endinterface

// File: rtl/vga_control_module_rect_hit.sv
// Combinational rectangle hit test: is the pixel inside the rectangle, and
// if so, does it fall in the inner border band of width BORDER.
module rect_hit
   import vga_pkg::*;
#(
   parameter int unsigned RECT_X0 = 200,
   parameter int unsigned RECT_X1 = 439,
   parameter int unsigned RECT_Y0 = 150,
   parameter int unsigned RECT_Y1 = 329,
   parameter int unsigned BORDER  = 4
) (
   input  logic [PIX_W-1:0] x,
   input  logic [PIX_W-1:0] y,
   output logic             in_rect,
   output logic             on_border
);

   // 11-bit limits so X0+BORDER cannot wrap; X1-BORDER clamps at 0, which is
   // harmless because in that case the left band already covers the rectangle.
   localparam logic [PIX_W:0] X_LO  = 11'(RECT_X0);
   localparam logic [PIX_W:0] X_HI  = 11'(RECT_X1);
   localparam logic [PIX_W:0] Y_LO  = 11'(RECT_Y0);
   localparam logic [PIX_W:0] Y_HI  = 11'(RECT_Y1);
   localparam logic [PIX_W:0] XB_LO = 11'(RECT_X0 + BORDER);
   localparam logic [PIX_W:0] YB_LO = 11'(RECT_Y0 + BORDER);
   localparam logic [PIX_W:0] XB_HI = 11'((RECT_X1 >= BORDER) ? (RECT_X1 - BORDER) : 0);
   localparam logic [PIX_W:0] YB_HI = 11'((RECT_Y1 >= BORDER) ? (RECT_Y1 - BORDER) : 0);

   logic [PIX_W:0] xe;
   logic [PIX_W:0] ye;

   always_comb begin
      xe        = {1'b0, x};
      ye        = {1'b0, y};
      in_rect   = (xe >= X_LO) && (xe <= X_HI) && (ye >= Y_LO) && (ye <= Y_HI);
      on_border = in_rect && ((xe < XB_LO) || (xe > XB_HI) ||
                              (ye < YB_LO) || (ye > YB_HI));
   end

endmodule

// File: rtl/vga_control_module.sv
// Pixel colour generator: one bordered rectangle on a solid background,
// blanked outside active video, registered once on VGA_CLK.
module vga_control_module
   import vga_pkg::*;
#(
   parameter int unsigned RECT_X0 = 200,
   parameter int unsigned RECT_X1 = 439,
   parameter int unsigned RECT_Y0 = 150,
   parameter int unsigned RECT_Y1 = 329,
   parameter int unsigned BORDER  = 4
) (
   input  logic                 VGA_CLK,
   input  logic                 RST_N,
   vga_control_module_if.slave  vga
);

   if (!(RECT_X0 <= RECT_X1 && RECT_X1 < H_ACTIVE &&
         RECT_Y0 <= RECT_Y1 && RECT_Y1 < V_ACTIVE && BORDER >= 1)) begin : g_bad_params
      $error("vga_control_module: illegal rectangle geometry");
   end

   logic    in_rect;
   logic    on_border;
   logic    blank;
   rgb332_t rgb_d;
   rgb332_t rgb_q;

   rect_hit #(
      .RECT_X0 (RECT_X0),
      .RECT_X1 (RECT_X1),
      .RECT_Y0 (RECT_Y0),
      .RECT_Y1 (RECT_Y1),
      .BORDER  (BORDER)
   ) u_rect_hit (
      .x         (vga.X),
      .y         (vga.Y),
      .in_rect   (in_rect),
      .on_border (on_border)
   );

   always_comb begin
      blank = !vga.valid ||
              (vga.X >= PIX_W'(H_ACTIVE)) ||
              (vga.Y >= PIX_W'(V_ACTIVE));
      rgb_d = C_BG;
      if (blank)          rgb_d = C_BLANK;
      else if (on_border) rgb_d = C_BORDER;
      else if (in_rect)   rgb_d = C_FILL;
   end

   // RST_N is active-high despite its name.
   always_ff @(posedge VGA_CLK) begin
      if (RST_N) rgb_q <= C_BLANK;
      else       rgb_q <= rgb_d;
   end

   assign vga.VGA_R = rgb_q[R_HI:R_LO];
   assign vga.VGA_G = rgb_q[G_HI:G_LO];
   assign vga.VGA_B = rgb_q[B_HI:B_LO];

endmodule

// File: tb/tb_vga_control_module.sv
// Self-checking bench for vga_control_module: directed pixels plus a
// row-sampled frame sweep, with expected colours queued at drive time.
module tb_vga_control_module;

   logic clk = 1'b0;
   logic rst = 1'b1;

   vga_control_module_if vif ();

   vga_control_module dut (
      .VGA_CLK (clk),
      .RST_N   (rst),
      .vga     (vif.slave)
   );

   always #5 clk = ~clk;

   logic [7:0] exp_q[$];
   int         n_checks = 0;
   int         n_errors = 0;
   bit         count_en = 1'b0;
   int         cnt_ff = 0;
   int         cnt_e0 = 0;
   int         cnt_03 = 0;
   int         cnt_00 = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Independent reference for one pixel with the default geometry.
   function automatic logic [7:0] ref_rgb(input int x, input int y, input bit v);
      bit inr;
      bit brd;
      if (!v || x >= 640 || y >= 480) return 8'h00;
      inr = (x >= 200 && x <= 439 && y >= 150 && y <= 329);
      brd = inr && (x <= 203 || x >= 436 || y <= 153 || y >= 326);
      if (brd) return 8'hFF;
      if (inr) return 8'hE0;
      return 8'h03;
   endfunction

   task automatic apply(input int x, input int y, input bit v,
                        input logic [7:0] exp, input string tag,
                        output logic [7:0] got);
      @(negedge clk);
      vif.X     = 10'(x);
      vif.Y     = 10'(y);
      vif.valid = v;
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      got = {vif.VGA_R, vif.VGA_G, vif.VGA_B};
      if (exp_q.size() == 0) begin
         chk({tag, "_queue_empty"}, 1, 0);
      end else begin
         chk(tag, got, exp_q.pop_front());
      end
      if (count_en) begin
         case (got)
            8'hFF:   cnt_ff++;
            8'hE0:   cnt_e0++;
            8'h03:   cnt_03++;
            default: cnt_00++;
         endcase
      end
   endtask

   typedef struct { int x; int y; logic [7:0] exp; } pix_t;

   initial begin
      logic [7:0] got;
      pix_t edges[$];
      int ex_ff;
      int ex_e0;
      int ex_03;
      int ex_00;

      vif.X = '0;
      vif.Y = '0;
      vif.valid = 1'b0;

      // Reset held for two cycles on a fill pixel, then released.
      rst = 1'b1;
      apply(300, 240, 1'b1, 8'h00, "reset_c0", got);
      apply(300, 240, 1'b1, 8'h00, "reset_c1", got);
      rst = 1'b0;
      apply(300, 240, 1'b1, 8'hE0, "post_reset", got);

      apply(10, 10, 1'b1, 8'h03, "bg", got);
      chk("bg_r", int'(got[7:5]), 0);
      chk("bg_g", int'(got[4:2]), 0);
      chk("bg_b", int'(got[1:0]), 3);
      apply(300, 240, 1'b1, 8'hE0, "fill", got);
      chk("fill_r", int'(got[7:5]), 7);
      chk("fill_g", int'(got[4:2]), 0);
      chk("fill_b", int'(got[1:0]), 0);
      apply(204, 154, 1'b1, 8'hE0, "fill_corner", got);

      edges = '{'{199,240,8'h03}, '{200,240,8'hFF}, '{203,240,8'hFF},
                '{204,240,8'hE0}, '{435,240,8'hE0}, '{436,240,8'hFF},
                '{439,240,8'hFF}, '{440,240,8'h03},
                '{300,149,8'h03}, '{300,150,8'hFF}, '{300,153,8'hFF},
                '{300,154,8'hE0}, '{300,325,8'hE0}, '{300,326,8'hFF},
                '{300,329,8'hFF}, '{300,330,8'h03}};
      foreach (edges[i])
         apply(edges[i].x, edges[i].y, 1'b1, edges[i].exp,
               $sformatf("edge_x%0d_y%0d", edges[i].x, edges[i].y), got);

      apply(300, 240, 1'b0, 8'h00, "blank_valid0", got);
      apply(640, 10,  1'b1, 8'h00, "blank_x640", got);
      apply(10,  480, 1'b1, 8'h00, "blank_y480", got);
      apply(1023, 1023, 1'b1, 8'h00, "blank_xy_max", got);

      // Reset asserted mid-frame on a border pixel must still win.
      rst = 1'b1;
      apply(200, 240, 1'b1, 8'h00, "reset_midframe", got);
      rst = 1'b0;
      apply(200, 240, 1'b1, 8'hFF, "after_mid_reset", got);

      // Frame sweep over every 7th line; expected counts from geometry per row.
      ex_ff = 0; ex_e0 = 0; ex_03 = 0; ex_00 = 0;
      for (int y = 0; y < 525; y += 7) begin
         if (y >= 480) begin
            ex_00 += 800;
         end else begin
            ex_00 += 160;
            if (y >= 150 && y <= 329) begin
               ex_03 += 400;
               if (y <= 153 || y >= 326) ex_ff += 240;
               else begin ex_ff += 8; ex_e0 += 232; end
            end else begin
               ex_03 += 640;
            end
         end
      end

      count_en = 1'b1;
      for (int y = 0; y < 525; y += 7) begin
         for (int x = 0; x < 800; x++) begin
            bit v;
            v = (x < 640) && (y < 480);
            apply(x, y, v, ref_rgb(x, y, v), "sweep", got);
         end
      end
      count_en = 1'b0;

      chk("count_ff", cnt_ff, ex_ff);
      chk("count_e0", cnt_e0, ex_e0);
      chk("count_03", cnt_03, ex_03);
      chk("count_00", cnt_00, ex_00);
      chk("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
